// File: rtl/hdmi_tx_config_ctrl_pkg.sv
// Shared types and ADV7511 register map for the HDMI transmitter init controller.
package hdmi_tx_config_ctrl_pkg;

  // Encoding is exposed on cfg_state for debug LEDs, so values are fixed.
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StSettle = 3'd1,
    StWrite  = 3'd2,
    StWait   = 3'd3,
    StNext   = 3'd4,
    StDone   = 3'd5,
    StError  = 3'd6
  } cfg_state_e;

  // ADV7511 register addresses used by the init table.
  localparam logic [7:0] AdvRegPowerDown  = 8'h41;
  localparam logic [7:0] AdvRegFixed98    = 8'h98;
  localparam logic [7:0] AdvRegFixed9a    = 8'h9A;
  localparam logic [7:0] AdvRegFixed9c    = 8'h9C;
  localparam logic [7:0] AdvRegFixed9d    = 8'h9D;
  localparam logic [7:0] AdvRegFixedA2    = 8'hA2;
  localparam logic [7:0] AdvRegFixedA3    = 8'hA3;
  localparam logic [7:0] AdvRegFixedE0    = 8'hE0;
  localparam logic [7:0] AdvRegFixedF9    = 8'hF9;
  localparam logic [7:0] AdvRegInputId    = 8'h15;
  localparam logic [7:0] AdvRegVideoStyle = 8'h16;
  localparam logic [7:0] AdvRegHdmiMode   = 8'hAF;

endpackage

// File: rtl/hdmi_tx_init_rom.sv
// Combinational init table: index -> {register address, write data}.
module hdmi_tx_init_rom
  import hdmi_tx_config_ctrl_pkg::*;
#(
  parameter int unsigned IDX_W = 4
) (
  input  logic [IDX_W-1:0] idx_i,
  output logic [7:0]       reg_addr_o,
  output logic [7:0]       wdata_o
);

  // Table lookup; out-of-range indices read as zero.
  always_comb begin
    reg_addr_o = 8'h00;
    wdata_o    = 8'h00;
    case (int'(idx_i))
      0:  begin reg_addr_o = AdvRegPowerDown;  wdata_o = 8'h10; end
      1:  begin reg_addr_o = AdvRegFixed98;    wdata_o = 8'h03; end
      2:  begin reg_addr_o = AdvRegFixed9a;    wdata_o = 8'hE0; end
      3:  begin reg_addr_o = AdvRegFixed9c;    wdata_o = 8'h30; end
      4:  begin reg_addr_o = AdvRegFixed9d;    wdata_o = 8'h61; end
      5:  begin reg_addr_o = AdvRegFixedA2;    wdata_o = 8'hA4; end
      6:  begin reg_addr_o = AdvRegFixedA3;    wdata_o = 8'hA4; end
      7:  begin reg_addr_o = AdvRegFixedE0;    wdata_o = 8'hD0; end
      8:  begin reg_addr_o = AdvRegFixedF9;    wdata_o = 8'h00; end
      9:  begin reg_addr_o = AdvRegInputId;    wdata_o = 8'h00; end
      10: begin reg_addr_o = AdvRegVideoStyle; wdata_o = 8'h30; end
      11: begin reg_addr_o = AdvRegHdmiMode;   wdata_o = 8'h06; end
      default: begin reg_addr_o = 8'h00; wdata_o = 8'h00; end
    endcase
  end

endmodule

// File: rtl/hdmi_tx_config_ctrl.sv
// HDMI transmitter configuration controller: debounces hot-plug, waits for the
// sink to settle, then streams the init table to a byte-level I2C master with
// per-register NACK retry.
module hdmi_tx_config_ctrl
  import hdmi_tx_config_ctrl_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR        = 7'h39,
  parameter int unsigned NUM_REGS        = 12,
  parameter int unsigned DEBOUNCE_CYCLES = 1024,
  parameter int unsigned SETTLE_CYCLES   = 16384,
  parameter int unsigned MAX_RETRY       = 3
) (
  input  logic       clk_pixel,
  input  logic       rst_n,
  input  logic       hdmi_hpd,
  input  logic       cfg_restart,
  output logic       i2c_req,
  output logic [6:0] i2c_dev_addr,
  output logic [7:0] i2c_reg_addr,
  output logic [7:0] i2c_wdata,
  input  logic       i2c_done,
  input  logic       i2c_nack,
  output logic       cfg_busy,
  output logic       cfg_done,
  output logic       cfg_error,
  output logic       hpd_stable,
  output logic [2:0] cfg_state
);

  localparam int unsigned IdxW   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int unsigned DebW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned SetW   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [IdxW-1:0]   LastIdx  = IdxW'(NUM_REGS - 1);
  localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRY);
  localparam logic [DebW-1:0]   DebLast  = DebW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SetW-1:0]   SetLast  = SetW'(SETTLE_CYCLES - 1);

  logic              hpd_meta_q, hpd_sync_q, hpd_stable_q;
  logic [DebW-1:0]   deb_cnt_q;
  cfg_state_e        state_q;
  logic [IdxW-1:0]   idx_q;
  logic [RetryW-1:0] retry_q;
  logic [SetW-1:0]   settle_cnt_q;
  logic              req_q;
  logic              restart_pend_q;
  logic [6:0]        dev_addr_q;
  logic [7:0]        reg_addr_q, wdata_q;
  logic [7:0]        rom_reg_addr, rom_wdata;
  logic              abort;

  hdmi_tx_init_rom #(
    .IDX_W(IdxW)
  ) u_init_rom (
    .idx_i     (idx_q),
    .reg_addr_o(rom_reg_addr),
    .wdata_o   (rom_wdata)
  );

  // Two-flop synchroniser, then accept a new level only after it holds long enough.
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      hpd_meta_q   <= 1'b0;
      hpd_sync_q   <= 1'b0;
      hpd_stable_q <= 1'b0;
      deb_cnt_q    <= '0;
    end else begin
      hpd_meta_q <= hdmi_hpd;
      hpd_sync_q <= hpd_meta_q;
      if (hpd_sync_q == hpd_stable_q) begin
        deb_cnt_q <= '0;
      end else if (deb_cnt_q == DebLast) begin
        hpd_stable_q <= hpd_sync_q;
        deb_cnt_q    <= '0;
      end else begin
        deb_cnt_q <= deb_cnt_q + 1'b1;
      end
    end
  end

  assign abort = !hpd_stable_q || cfg_restart;

  // Sequencer; an outstanding I2C transaction is always completed before
  // honouring HPD loss or restart, so the master never sees a torn request.
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      idx_q          <= '0;
      retry_q        <= '0;
      settle_cnt_q   <= '0;
      req_q          <= 1'b0;
      restart_pend_q <= 1'b0;
      dev_addr_q     <= '0;
      reg_addr_q     <= '0;
      wdata_q        <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (hpd_stable_q && !cfg_restart) begin
            state_q      <= StSettle;
            settle_cnt_q <= '0;
          end
        end
        StSettle: begin
          if (abort) begin
            state_q <= StIdle;
          end else if (settle_cnt_q == SetLast) begin
            state_q <= StWrite;
            idx_q   <= '0;
            retry_q <= '0;
          end else begin
            settle_cnt_q <= settle_cnt_q + 1'b1;
          end
        end
        StWrite: begin
          req_q      <= 1'b1;
          dev_addr_q <= DEV_ADDR;
          reg_addr_q <= rom_reg_addr;
          wdata_q    <= rom_wdata;
          state_q    <= StWait;
          if (cfg_restart) restart_pend_q <= 1'b1;
        end
        StWait: begin
          if (i2c_done) begin
            req_q          <= 1'b0;
            restart_pend_q <= 1'b0;
            // Abort takes priority over both ACK and NACK outcomes.
            if (abort || restart_pend_q) begin
              state_q <= StIdle;
            end else if (!i2c_nack) begin
              state_q <= StNext;
            end else if (retry_q < RetryMax) begin
              retry_q <= retry_q + 1'b1;
              state_q <= StWrite;
            end else begin
              state_q <= StError;
            end
          end else if (cfg_restart) begin
            restart_pend_q <= 1'b1;
          end
        end
        StNext: begin
          if (abort) begin
            state_q <= StIdle;
          end else if (idx_q < LastIdx) begin
            idx_q   <= idx_q + 1'b1;
            retry_q <= '0;
            state_q <= StWrite;
          end else begin
            state_q <= StDone;
          end
        end
        StDone, StError: begin
          if (abort) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Status decode straight from the state register.
  always_comb begin
    cfg_busy  = (state_q == StSettle) || (state_q == StWrite) ||
                (state_q == StWait)   || (state_q == StNext);
    cfg_done  = (state_q == StDone);
    cfg_error = (state_q == StError);
  end

  assign cfg_state    = state_q;
  assign hpd_stable   = hpd_stable_q;
  assign i2c_req      = req_q;
  assign i2c_dev_addr = dev_addr_q;
  assign i2c_reg_addr = reg_addr_q;
  assign i2c_wdata    = wdata_q;

endmodule

// File: tb/tb_hdmi_tx_config_ctrl.sv
// Bench for hdmi_tx_config_ctrl: randomized I2C responder, request scoreboard
// and an expected-sequence model built from the init table and a NACK plan.
module tb_hdmi_tx_config_ctrl;

  localparam int MaxRetry = 3;
  localparam int Budget   = 6000;

  logic       clk_pixel = 1'b0;
  logic       rst_n, hdmi_hpd, cfg_restart;
  logic       i2c_req, i2c_done, i2c_nack;
  logic [6:0] i2c_dev_addr;
  logic [7:0] i2c_reg_addr, i2c_wdata;
  logic       cfg_busy, cfg_done, cfg_error, hpd_stable;
  logic [2:0] cfg_state;

  always #5 clk_pixel = ~clk_pixel;

  hdmi_tx_config_ctrl #(
    .DEV_ADDR       (7'h39),
    .NUM_REGS       (12),
    .DEBOUNCE_CYCLES(1024),
    .SETTLE_CYCLES  (200),
    .MAX_RETRY      (MaxRetry)
  ) dut (
    .clk_pixel   (clk_pixel),
    .rst_n       (rst_n),
    .hdmi_hpd    (hdmi_hpd),
    .cfg_restart (cfg_restart),
    .i2c_req     (i2c_req),
    .i2c_dev_addr(i2c_dev_addr),
    .i2c_reg_addr(i2c_reg_addr),
    .i2c_wdata   (i2c_wdata),
    .i2c_done    (i2c_done),
    .i2c_nack    (i2c_nack),
    .cfg_busy    (cfg_busy),
    .cfg_done    (cfg_done),
    .cfg_error   (cfg_error),
    .hpd_stable  (hpd_stable),
    .cfg_state   (cfg_state)
  );

  logic [7:0] tbl_reg [12] = '{8'h41, 8'h98, 8'h9A, 8'h9C, 8'h9D, 8'hA2,
                               8'hA3, 8'hE0, 8'hF9, 8'h15, 8'h16, 8'hAF};
  logic [7:0] tbl_dat [12] = '{8'h10, 8'h03, 8'hE0, 8'h30, 8'h61, 8'hA4,
                               8'hA4, 8'hD0, 8'h00, 8'h00, 8'h30, 8'h06};

  int          plan [12];
  int          nack_left [12];
  logic [15:0] got_q [$];
  logic [15:0] exp_q [$];
  bit          hold_en;
  logic [7:0]  hold_reg;
  bit          saw_stable;
  int          stab_err;
  int          n_tests, n_fail;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // I2C slave stand-in: one done pulse per request after a random delay.
  initial begin
    bit served;
    int dly;
    served   = 0;
    dly      = 0;
    i2c_done = 1'b0;
    i2c_nack = 1'b0;
    forever begin
      @(negedge clk_pixel);
      i2c_done = 1'b0;
      i2c_nack = 1'b0;
      if (!i2c_req) begin
        served = 0;
        dly    = $urandom_range(0, 4);
      end else if (!served && !(hold_en && i2c_reg_addr == hold_reg)) begin
        if (dly == 0) begin
          i2c_done = 1'b1;
          served   = 1;
          for (int i = 0; i < 12; i++) begin
            if (tbl_reg[i] == i2c_reg_addr && nack_left[i] > 0) begin
              nack_left[i]--;
              i2c_nack = 1'b1;
            end
          end
        end else begin
          dly--;
        end
      end
    end
  end

  // Request monitor: log each new request and watch its fields while pending.
  initial begin
    logic        prev_req;
    logic [22:0] lat;
    prev_req = 1'b0;
    lat      = '0;
    forever begin
      @(negedge clk_pixel);
      if (hpd_stable) saw_stable = 1;
      if (i2c_req && !prev_req) begin
        got_q.push_back({i2c_reg_addr, i2c_wdata});
        lat = {i2c_dev_addr, i2c_reg_addr, i2c_wdata};
        check_eq("dev_addr", 32'(i2c_dev_addr), 32'h39);
      end else if (i2c_req && {i2c_dev_addr, i2c_reg_addr, i2c_wdata} != lat) begin
        stab_err++;
      end
      prev_req = i2c_req;
    end
  end

  // Expected request stream from the table and the NACK plan.
  task automatic build_expect(output bit exp_err);
    exp_q.delete();
    exp_err = 0;
    for (int i = 0; i < 12 && !exp_err; i++) begin
      int tries;
      if (plan[i] > MaxRetry) begin
        tries   = MaxRetry + 1;
        exp_err = 1;
      end else begin
        tries = plan[i] + 1;
      end
      repeat (tries) exp_q.push_back({tbl_reg[i], tbl_dat[i]});
    end
  endtask

  task automatic run_and_check(input string tag);
    bit exp_err;
    bit hit;
    build_expect(exp_err);
    hit = 0;
    for (int c = 0; c < Budget && !hit; c++) begin
      @(negedge clk_pixel);
      if (cfg_done || cfg_error) hit = 1;
    end
    check_eq({tag, "_finished"}, 32'(hit), 32'd1);
    repeat (50) @(negedge clk_pixel);
    check_eq({tag, "_done"}, 32'(cfg_done), 32'(!exp_err));
    check_eq({tag, "_error"}, 32'(cfg_error), 32'(exp_err));
    check_eq({tag, "_busy"}, 32'(cfg_busy), 32'd0);
    check_eq({tag, "_state"}, 32'(cfg_state), exp_err ? 32'd6 : 32'd5);
    check_eq({tag, "_nreq"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) check_eq({tag, "_req"}, 32'(got_q[i]), 32'(exp_q[i]));
    end
  endtask

  task automatic apply_reset();
    rst_n       = 1'b0;
    hdmi_hpd    = 1'b0;
    cfg_restart = 1'b0;
    repeat (3) @(negedge clk_pixel);
    rst_n = 1'b1;
    @(negedge clk_pixel);
  endtask

  task automatic start_run();
    nack_left = plan;
    got_q.delete();
    hdmi_hpd = 1'b1;
  endtask

  task automatic wait_hold_req(input string tag);
    bit hit;
    hit = 0;
    for (int c = 0; c < Budget && !hit; c++) begin
      @(negedge clk_pixel);
      if (i2c_req && i2c_reg_addr == hold_reg) hit = 1;
    end
    check_eq(tag, 32'(hit), 32'd1);
  endtask

  initial begin
    int n9c;
    bit hit;
    n_tests     = 0;
    n_fail      = 0;
    stab_err    = 0;
    saw_stable  = 0;
    hold_en     = 0;
    hold_reg    = 8'h00;
    rst_n       = 1'b0;
    hdmi_hpd    = 1'b0;
    cfg_restart = 1'b0;
    foreach (plan[i]) plan[i] = 0;
    nack_left = plan;
    repeat (3) @(negedge clk_pixel);

    // Reset values.
    check_eq("rst_req", 32'(i2c_req), 32'd0);
    check_eq("rst_busy", 32'(cfg_busy), 32'd0);
    check_eq("rst_done", 32'(cfg_done), 32'd0);
    check_eq("rst_error", 32'(cfg_error), 32'd0);
    check_eq("rst_hpd", 32'(hpd_stable), 32'd0);
    check_eq("rst_state", 32'(cfg_state), 32'd0);
    check_eq("rst_data", 32'({i2c_dev_addr, i2c_reg_addr, i2c_wdata}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk_pixel);

    // Nominal bring-up, all ACKed.
    start_run();
    run_and_check("nominal");

    // Randomized NACK plans (never exhausting retries), re-entered via restart.
    for (int r = 0; r < 2; r++) begin
      foreach (plan[i]) plan[i] = $urandom_range(0, 2);
      nack_left = plan;
      got_q.delete();
      cfg_restart = 1'b1;
      @(negedge clk_pixel);
      cfg_restart = 1'b0;
      check_eq("restart_idle", 32'(cfg_state), 32'd0);
      run_and_check("random");
    end

    // Short HPD glitch must be rejected.
    foreach (plan[i]) plan[i] = 0;
    apply_reset();
    saw_stable = 0;
    got_q.delete();
    hdmi_hpd = 1'b1;
    repeat (500) @(negedge clk_pixel);
    hdmi_hpd = 1'b0;
    repeat (2000) @(negedge clk_pixel);
    check_eq("glitch_stable", 32'(saw_stable), 32'd0);
    check_eq("glitch_nreq", 32'(got_q.size()), 32'd0);

    // Two NACKs on index 3, then ACK.
    apply_reset();
    plan[3] = 2;
    start_run();
    run_and_check("nack3");
    n9c = 0;
    foreach (got_q[i]) if (got_q[i][15:8] == 8'h9C) n9c++;
    check_eq("nack3_count9c", 32'(n9c), 32'd3);

    // Four NACKs on index 5 exhaust the retries.
    apply_reset();
    foreach (plan[i]) plan[i] = 0;
    plan[5] = 4;
    start_run();
    run_and_check("nack5");
    repeat (300) @(negedge clk_pixel);
    check_eq("nack5_nreq_after", 32'(got_q.size()), 32'd9);
    check_eq("nack5_state_after", 32'(cfg_state), 32'd6);
    check_eq("nack5_req_after", 32'(i2c_req), 32'd0);

    // HPD loss while waiting on index 7: finish the transfer, then IDLE.
    apply_reset();
    foreach (plan[i]) plan[i] = 0;
    hold_reg = 8'hE0;
    hold_en  = 1;
    start_run();
    wait_hold_req("hpdfall_reach_idx7");
    hdmi_hpd = 1'b0;
    repeat (1200) @(negedge clk_pixel);
    check_eq("hpdfall_stable", 32'(hpd_stable), 32'd0);
    check_eq("hpdfall_req_held", 32'(i2c_req), 32'd1);
    check_eq("hpdfall_state_wait", 32'(cfg_state), 32'd3);
    hold_en = 0;
    hit = 0;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge clk_pixel);
      if (cfg_state == 3'd0) hit = 1;
    end
    check_eq("hpdfall_to_idle", 32'(hit), 32'd1);
    check_eq("hpdfall_req_low", 32'(i2c_req), 32'd0);
    check_eq("hpdfall_nreq", 32'(got_q.size()), 32'd8);
    start_run();
    run_and_check("rerise");

    // Reset during a pending request drops i2c_req without a clock edge.
    apply_reset();
    hold_reg = 8'h9D;
    hold_en  = 1;
    start_run();
    wait_hold_req("rst_mid_reach");
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_req_async", 32'(i2c_req), 32'd0);
    check_eq("rst_mid_state_async", 32'(cfg_state), 32'd0);
    hold_en = 0;
    @(negedge clk_pixel);
    rst_n = 1'b1;
    @(negedge clk_pixel);
    check_eq("rst_rel_outs",
             32'({i2c_req, cfg_busy, cfg_done, cfg_error, hpd_stable, cfg_state}), 32'd0);
    check_eq("rst_rel_data", 32'({i2c_dev_addr, i2c_reg_addr, i2c_wdata}), 32'd0);

    check_eq("req_fields_stable", 32'(stab_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hdmi_tx_config_ctrl.md
HDMI_TX_CONFIG_CTRL -- requirements
Module: hdmi_tx_config_ctrl

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h39, 7-bit I2C address of the external HDMI transmitter.
REQ-002 SHALL have parameter NUM_REGS, default 12, number of register writes in the init table.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 1024, cycles hdmi_hpd must be stable before it is accepted.
REQ-004 SHALL have parameter SETTLE_CYCLES, default 16384, delay from debounced HPD rise to the first write.
REQ-005 SHALL have parameter MAX_RETRY, default 3, NACK retries per register before error.
REQ-006 SHALL have port clk_pixel, input, 1, sole clock.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port hdmi_hpd, input, 1, raw hot-plug detect (asynchronous to clk_pixel).
REQ-009 SHALL have port cfg_restart, input, 1, single-cycle pulse requesting full re-initialisation.
REQ-010 SHALL have ports i2c_req (output, 1), i2c_dev_addr (output, 7), i2c_reg_addr (output, 8) and i2c_wdata (output, 8): write request to the byte-level I2C master.
REQ-011 SHALL have ports i2c_done (input, 1), one-cycle completion pulse, and i2c_nack (input, 1), valid only when i2c_done is high.
REQ-012 SHALL have ports cfg_busy, cfg_done and cfg_error (outputs, 1 each), plus hpd_stable (output, 1, the debounced HPD).
REQ-013 SHALL have port cfg_state, output, 3, current FSM state encoding, for debug LEDs.

Function
REQ-014 SHALL synchronise hdmi_hpd through 2 flops, then debounce it.
- The debounce counter resets on every change of the synchronised value.
- hpd_stable updates when the counter reaches DEBOUNCE_CYCLES-1.
REQ-015 SHALL implement FSM states IDLE=0, SETTLE=1, WRITE=2, WAIT=3, NEXT=4, DONE=5, ERROR=6.
REQ-016 Transitions SHALL be:
- IDLE -> SETTLE on hpd_stable=1.
- SETTLE -> WRITE after SETTLE_CYCLES cycles; index and retry count are cleared on this transition.
- WRITE -> WAIT (i2c_req asserted).
- WAIT -> NEXT on i2c_done with i2c_nack=0.
- NEXT -> WRITE if index < NUM_REGS-1, otherwise -> DONE.
REQ-017 On i2c_done with i2c_nack=1, the FSM SHALL:
- increment retry and return to WRITE for the same index if retry < MAX_RETRY;
- otherwise go to ERROR.
REQ-018 i2c_req SHALL rise the cycle after WRITE is entered and stay high until the cycle after i2c_done. It SHALL never be high for two consecutive transactions without one low cycle between them.
REQ-019 i2c_dev_addr, i2c_reg_addr and i2c_wdata SHALL be registered and stable for the whole time i2c_req is high. i2c_dev_addr SHALL equal DEV_ADDR.
REQ-020 The index counter SHALL be $clog2(NUM_REGS) bits and the retry counter $clog2(MAX_RETRY+1) bits; neither SHALL wrap.
REQ-021 cfg_done SHALL be high only in DONE, cfg_error only in ERROR, and cfg_busy in SETTLE, WRITE, WAIT and NEXT.
REQ-022 hpd_stable falling SHALL send IDLE, SETTLE, NEXT, DONE or ERROR to IDLE immediately. In WRITE/WAIT the FSM SHALL finish the outstanding transaction (await i2c_done) and then go to IDLE.
REQ-023 cfg_restart SHALL behave like a loss of HPD: same immediate/deferred rule, then re-enter via IDLE. If cfg_restart and i2c_done coincide, cfg_restart SHALL win.
REQ-024 Simultaneous HPD fall and i2c_done with NACK SHALL go to IDLE, not ERROR.
REQ-025 An i2c_done received outside WAIT SHALL be ignored.

Reset
REQ-026 While rst_n=0 the block SHALL hold:
- state IDLE;
- i2c_req, cfg_busy, cfg_done, cfg_error and hpd_stable at 0;
- address/data outputs, index, retry and counters at 0.
REQ-027 Reset assertion mid-transaction SHALL drop i2c_req asynchronously; no further transaction SHALL start until debounce and settle complete again.

Structure
REQ-028 A shared package SHALL hold the FSM state enumeration and the ADV7511 register-address constants.
REQ-029 The init table SHALL be a combinational sub-module hdmi_tx_init_rom (index -> {reg_addr, wdata}) holding, in order: 41=10, 98=03, 9A=E0, 9C=30, 9D=61, A2=A4, A3=A4, E0=D0, F9=00, 15=00, 16=30, AF=06.

Verification
REQ-030 HPD stable high, every transfer ACKed -> exactly 12 requests in ROM order, first at reg 0x41 with data 0x10, last at reg 0xAF with data 0x06, then cfg_done=1.
REQ-031 HPD glitch of 500 cycles (DEBOUNCE_CYCLES=1024) -> hpd_stable stays 0 and i2c_req never asserts.
REQ-032 NACK on index 3 twice then ACK -> reg 0x9C is requested 3 times, then the sequence completes with cfg_done=1.
REQ-033 NACK on index 5 four times -> 4 requests for reg 0xA2, cfg_error=1, cfg_state=6, no further requests.
REQ-034 HPD falls while in WAIT at index 7 -> i2c_req is held until i2c_done, FSM goes to IDLE; HPD re-rise -> a full 12-write sequence runs from index 0.
REQ-035 rst_n pulsed low while i2c_req=1 -> i2c_req drops without waiting for a clock edge; all outputs read 0 within one cycle of reset release.
